// File: rtl/mm_engine_pkg.sv
// rtl/mm_engine_pkg.sv - shared sizing defaults and scheduler state type for the matmul engine
package mm_engine_pkg;

  localparam int DEFAULT_N                    = 4;
  localparam int DEFAULT_MEMORY_ADDRESS_BITS  = 64;
  localparam int DEFAULT_MAX_MATRIX_LENGTH    = 4096;
  localparam int DEFAULT_COUNTER_BITS         = $clog2(DEFAULT_MAX_MATRIX_LENGTH + 1);
  localparam int DEFAULT_REPEATS_COUNTER_BITS = $clog2(DEFAULT_MAX_MATRIX_LENGTH / DEFAULT_N + 1);

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_RUN,
    SCHED_DRAIN,
    SCHED_DONE
  } sched_state_t;

endpackage

// File: rtl/tile_issue_channel.sv
// rtl/tile_issue_channel.sv - per-buffer instruction payload register, address accumulator and tile counter
module tile_issue_channel
  import mm_engine_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_MEMORY_ADDRESS_BITS,
  parameter int LEN_W  = DEFAULT_COUNTER_BITS,
  parameter int REP_W  = DEFAULT_REPEATS_COUNTER_BITS,
  parameter bit WRAP   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  length_in,
  input  logic [REP_W-1:0]  repeats_in,
  input  logic [REP_W-1:0]  wrap_count,
  input  logic              fire,
  output logic [ADDR_W-1:0] address,
  output logic [LEN_W-1:0]  length,
  output logic [REP_W-1:0]  repeats,
  output logic [REP_W-1:0]  count
);

  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic [REP_W-1:0]  wrap_reg;
  logic [REP_W-1:0]  col;

  always_ff @(posedge clk) begin
    if (reset) begin
      address    <= '0;
      length     <= '0;
      repeats    <= '0;
      count      <= '0;
      col        <= '0;
      base_reg   <= '0;
      stride_reg <= '0;
      wrap_reg   <= '0;
    end else if (start) begin
      address    <= base;
      base_reg   <= base;
      stride_reg <= stride;
      length     <= length_in;
      repeats    <= repeats_in;
      wrap_reg   <= wrap_count;
      count      <= '0;
      col        <= '0;
    end else if (fire) begin
      // A wrapping channel walks columns inside a row, then rewinds to the base for the next row.
      if (WRAP && (col == wrap_reg - REP_W'(1))) begin
        col     <= '0;
        count   <= count + REP_W'(1);
        address <= base_reg;
      end else if (WRAP) begin
        col     <= col + REP_W'(1);
        address <= address + stride_reg;
      end else begin
        count   <= count + REP_W'(1);
        address <= address + stride_reg;
      end
    end
  end

endmodule

// File: rtl/mm_tile_scheduler.sv
// rtl/mm_tile_scheduler.sv - splits one matmul job into A/B tile instructions and reports completion after drain
module mm_tile_scheduler
  import mm_engine_pkg::*;
#(
  parameter int N                    = DEFAULT_N,
  parameter int MEMORY_ADDRESS_BITS  = DEFAULT_MEMORY_ADDRESS_BITS,
  parameter int MAX_MATRIX_LENGTH    = DEFAULT_MAX_MATRIX_LENGTH,
  parameter int COUNTER_BITS         = $clog2(MAX_MATRIX_LENGTH + 1),
  parameter int REPEATS_COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH / N + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]  a_base_address,
  input  logic [MEMORY_ADDRESS_BITS-1:0]  b_base_address,
  input  logic [REPEATS_COUNTER_BITS-1:0] row_tiles,
  input  logic [REPEATS_COUNTER_BITS-1:0] col_tiles,
  input  logic [COUNTER_BITS-1:0]         inner_length,
  output logic                            a_instruction_valid,
  input  logic                            a_instruction_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]  a_address,
  output logic [COUNTER_BITS-1:0]         a_length,
  output logic [REPEATS_COUNTER_BITS-1:0] a_repeats,
  output logic                            b_instruction_valid,
  input  logic                            b_instruction_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]  b_address,
  output logic [COUNTER_BITS-1:0]         b_length,
  output logic [REPEATS_COUNTER_BITS-1:0] b_repeats,
  output logic                            job_done
);

  sched_state_t                    state, state_next;
  logic [REPEATS_COUNTER_BITS-1:0] r_reg;
  logic [REPEATS_COUNTER_BITS-1:0] a_issued;
  logic [REPEATS_COUNTER_BITS-1:0] b_row;
  logic [MEMORY_ADDRESS_BITS-1:0]  stride;
  logic                            start;
  logic                            zero_job;
  logic                            a_fire;
  logic                            b_fire;

  assign stride   = MEMORY_ADDRESS_BITS'(inner_length) * MEMORY_ADDRESS_BITS'(N);
  assign zero_job = (row_tiles == '0) || (col_tiles == '0) || (inner_length == '0);
  assign a_fire   = a_instruction_valid && a_instruction_ready;
  assign b_fire   = b_instruction_valid && b_instruction_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCHED_IDLE;
      r_reg <= '0;
    end else begin
      state <= state_next;
      if (start) r_reg <= row_tiles;
    end
  end

  always_comb begin
    state_next          = state;
    job_ready           = 1'b0;
    job_done            = 1'b0;
    start               = 1'b0;
    a_instruction_valid = 1'b0;
    b_instruction_valid = 1'b0;
    unique case (state)
      SCHED_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          start      = 1'b1;
          state_next = zero_job ? SCHED_DONE : SCHED_RUN;
        end
      end
      SCHED_RUN: begin
        // B row i only goes out once A row i has been accepted (pre-edge a_issued).
        a_instruction_valid = (a_issued < r_reg);
        b_instruction_valid = (b_row < r_reg) && (b_row < a_issued);
        if ((a_issued == r_reg) && (b_row == r_reg)) state_next = SCHED_DRAIN;
      end
      SCHED_DRAIN: begin
        if (a_instruction_ready && b_instruction_ready) state_next = SCHED_DONE;
      end
      SCHED_DONE: begin
        job_done   = 1'b1;
        state_next = SCHED_IDLE;
      end
      default: state_next = SCHED_IDLE;
    endcase
  end

  tile_issue_channel #(
    .ADDR_W(MEMORY_ADDRESS_BITS),
    .LEN_W (COUNTER_BITS),
    .REP_W (REPEATS_COUNTER_BITS),
    .WRAP  (1'b0)
  ) u_a_channel (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base      (a_base_address),
    .stride    (stride),
    .length_in (inner_length),
    .repeats_in(col_tiles),
    .wrap_count(col_tiles),
    .fire      (a_fire),
    .address   (a_address),
    .length    (a_length),
    .repeats   (a_repeats),
    .count     (a_issued)
  );

  tile_issue_channel #(
    .ADDR_W(MEMORY_ADDRESS_BITS),
    .LEN_W (COUNTER_BITS),
    .REP_W (REPEATS_COUNTER_BITS),
    .WRAP  (1'b1)
  ) u_b_channel (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base      (b_base_address),
    .stride    (stride),
    .length_in (inner_length),
    .repeats_in(REPEATS_COUNTER_BITS'(1)),
    .wrap_count(col_tiles),
    .fire      (b_fire),
    .address   (b_address),
    .length    (b_length),
    .repeats   (b_repeats),
    .count     (b_row)
  );

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// tb/tb_mm_tile_scheduler.sv - directed self-checking bench for mm_tile_scheduler
module tb_mm_tile_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [63:0] a_base_address;
  logic [63:0] b_base_address;
  logic [10:0] row_tiles;
  logic [10:0] col_tiles;
  logic [12:0] inner_length;
  logic        a_instruction_valid;
  logic        a_instruction_ready;
  logic [63:0] a_address;
  logic [12:0] a_length;
  logic [10:0] a_repeats;
  logic        b_instruction_valid;
  logic        b_instruction_ready;
  logic [63:0] b_address;
  logic [12:0] b_length;
  logic [10:0] b_repeats;
  logic        job_done;

  mm_tile_scheduler dut (
    .clk                (clk),
    .reset              (reset),
    .job_valid          (job_valid),
    .job_ready          (job_ready),
    .a_base_address     (a_base_address),
    .b_base_address     (b_base_address),
    .row_tiles          (row_tiles),
    .col_tiles          (col_tiles),
    .inner_length       (inner_length),
    .a_instruction_valid(a_instruction_valid),
    .a_instruction_ready(a_instruction_ready),
    .a_address          (a_address),
    .a_length           (a_length),
    .a_repeats          (a_repeats),
    .b_instruction_valid(b_instruction_valid),
    .b_instruction_ready(b_instruction_ready),
    .b_address          (b_address),
    .b_length           (b_length),
    .b_repeats          (b_repeats),
    .job_done           (job_done)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cur_c        = 0;
  int cur_k        = 0;
  int done_cnt     = 0;

  logic [63:0] a_addr_q[$];
  logic [63:0] b_addr_q[$];
  logic        a_stall_prev = 1'b0;
  logic        b_stall_prev = 1'b0;
  logic [63:0] a_hold_addr  = '0;
  logic [63:0] b_hold_addr  = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: records accepted payloads, checks hold-under-stall and A-before-B ordering.
  always @(negedge clk) begin
    if (a_stall_prev) begin
      check_eq("a_hold_valid", 64'(a_instruction_valid), 64'd1);
      check_eq("a_hold_addr", a_address, a_hold_addr);
    end
    if (b_stall_prev) begin
      check_eq("b_hold_valid", 64'(b_instruction_valid), 64'd1);
      check_eq("b_hold_addr", b_address, b_hold_addr);
    end
    if (b_instruction_valid)
      check_eq("b_after_a", 64'(b_addr_q.size() < a_addr_q.size() * cur_c), 64'd1);
    if (a_instruction_valid && a_instruction_ready) begin
      a_addr_q.push_back(a_address);
      check_eq("a_len", 64'(a_length), 64'(cur_k));
      check_eq("a_rep", 64'(a_repeats), 64'(cur_c));
    end
    if (b_instruction_valid && b_instruction_ready) begin
      b_addr_q.push_back(b_address);
      check_eq("b_len", 64'(b_length), 64'(cur_k));
      check_eq("b_rep", 64'(b_repeats), 64'd1);
    end
    if (job_done) done_cnt++;
    a_stall_prev = a_instruction_valid && !a_instruction_ready && !reset;
    b_stall_prev = b_instruction_valid && !b_instruction_ready && !reset;
    a_hold_addr  = a_address;
    b_hold_addr  = b_address;
  end

  task automatic clear_mon();
    a_addr_q.delete();
    b_addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_job(input logic [63:0] ab, input logic [63:0] bb,
                           input int r, input int c, input int k);
    cur_c = c;
    cur_k = k;
    @(posedge clk);
    #1;
    a_base_address = ab;
    b_base_address = bb;
    row_tiles      = 11'(r);
    col_tiles      = 11'(c);
    inner_length   = 13'(k);
    job_valid      = 1'b1;
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (job_done) break;
    end
    check_eq({tag, "_done_seen"}, 64'(job_done), 64'd1);
  endtask

  // Expected tiles for the R=2, C=3, K=8, a_base=0x1000, b_base=0x2000 job (stride 0x20).
  task automatic check_basic_seq(input string tag);
    logic [63:0] ea[2];
    logic [63:0] eb[3];
    ea = '{64'h1000, 64'h1020};
    eb = '{64'h2000, 64'h2020, 64'h2040};
    check_eq({tag, "_a_count"}, 64'(a_addr_q.size()), 64'd2);
    check_eq({tag, "_b_count"}, 64'(b_addr_q.size()), 64'd6);
    for (int i = 0; i < 2; i++)
      if (i < a_addr_q.size()) check_eq({tag, "_a_addr"}, a_addr_q[i], ea[i]);
    for (int i = 0; i < 6; i++)
      if (i < b_addr_q.size()) check_eq({tag, "_b_addr"}, b_addr_q[i], eb[i % 3]);
    check_eq({tag, "_done_count"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    int cyc;
    reset               = 1'b1;
    job_valid           = 1'b0;
    a_base_address      = '0;
    b_base_address      = '0;
    row_tiles           = '0;
    col_tiles           = '0;
    inner_length        = '0;
    a_instruction_ready = 1'b1;
    b_instruction_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_job_ready", 64'(job_ready), 64'd1);
    check_eq("rst_a_valid", 64'(a_instruction_valid), 64'd0);
    check_eq("rst_b_valid", 64'(b_instruction_valid), 64'd0);
    check_eq("rst_a_addr", a_address, 64'd0);
    check_eq("rst_b_addr", b_address, 64'd0);
    check_eq("rst_lengths", 64'({a_length, b_length}), 64'd0);
    check_eq("rst_repeats", 64'({a_repeats, b_repeats}), 64'd0);
    check_eq("rst_job_done", 64'(job_done), 64'd0);
    reset = 1'b0;

    // Basic job, readies high: done lands on the 10th cycle after acceptance.
    clear_mon();
    start_job(64'h1000, 64'h2000, 2, 3, 8);
    wait_done("s1", 50, cyc);
    check_eq("s1_latency", 64'(cyc), 64'd10);
    check_eq("s1_ready_during_done", 64'(job_ready), 64'd0);
    @(negedge clk);
    check_eq("s1_done_one_cycle", 64'(job_done), 64'd0);
    check_eq("s1_ready_after", 64'(job_ready), 64'd1);
    check_basic_seq("s1");

    // Random B backpressure.
    clear_mon();
    start_job(64'h1000, 64'h2000, 2, 3, 8);
    cyc = 0;
    while (cyc < 400 && !job_done) begin
      @(posedge clk);
      #1 b_instruction_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      cyc++;
    end
    check_eq("s2_done_seen", 64'(job_done), 64'd1);
    b_instruction_ready = 1'b1;
    @(negedge clk);
    check_basic_seq("s2");

    // A ready held low for 20 cycles: no B may appear.
    clear_mon();
    a_instruction_ready = 1'b0;
    start_job(64'h1000, 64'h2000, 2, 3, 8);
    repeat (20) begin
      @(negedge clk);
      check_eq("s3_no_b_valid", 64'(b_instruction_valid), 64'd0);
    end
    check_eq("s3_a_waiting", 64'(a_instruction_valid), 64'd1);
    check_eq("s3_a_first_addr", a_address, 64'h1000);
    a_instruction_ready = 1'b1;
    wait_done("s3", 50, cyc);
    @(negedge clk);
    check_basic_seq("s3");

    // Zero column tiles, then zero inner length.
    for (int z = 0; z < 2; z++) begin
      clear_mon();
      if (z == 0) start_job(64'h1000, 64'h2000, 2, 0, 8);
      else        start_job(64'h1000, 64'h2000, 2, 3, 0);
      @(negedge clk);
      check_eq("s4_done_next", 64'(job_done), 64'd1);
      check_eq("s4_no_valids", 64'({a_instruction_valid, b_instruction_valid}), 64'd0);
      @(negedge clk);
      check_eq("s4_done_over", 64'(job_done), 64'd0);
      check_eq("s4_ready_back", 64'(job_ready), 64'd1);
      check_eq("s4_no_issue", 64'(a_addr_q.size() + b_addr_q.size()), 64'd0);
    end

    // Drain gating: B ready low for 10 cycles after the only B handshake.
    clear_mon();
    start_job(64'h3000, 64'h4000, 1, 1, 4);
    cyc = 0;
    while (cyc < 20 && b_addr_q.size() < 1) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("s5_b_issued", 64'(b_addr_q.size()), 64'd1);
    check_eq("s5_b_addr", (b_addr_q.size() > 0) ? b_addr_q[0] : 64'd0, 64'h4000);
    @(posedge clk);
    #1 b_instruction_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_eq("s5_no_done", 64'(job_done), 64'd0);
      check_eq("s5_not_ready", 64'(job_ready), 64'd0);
    end
    b_instruction_ready = 1'b1;
    wait_done("s5", 10, cyc);
    check_eq("s5_release_latency", 64'(cyc), 64'd1);

    // Reset mid-job after two B issues, then a clean rerun.
    clear_mon();
    @(negedge clk);
    start_job(64'h1000, 64'h2000, 2, 3, 8);
    cyc = 0;
    while (cyc < 20 && b_addr_q.size() < 2) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("s6_two_b", 64'(b_addr_q.size()), 64'd2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("s6_valids_low", 64'({a_instruction_valid, b_instruction_valid}), 64'd0);
    check_eq("s6_job_ready", 64'(job_ready), 64'd1);
    check_eq("s6_job_done", 64'(job_done), 64'd0);
    check_eq("s6_b_addr_clear", b_address, 64'd0);
    clear_mon();
    start_job(64'h1000, 64'h2000, 2, 3, 8);
    wait_done("s6", 50, cyc);
    check_eq("s6_latency", 64'(cyc), 64'd10);
    @(negedge clk);
    check_basic_seq("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mm_tile_scheduler.md
# mm_tile_scheduler

Job-level scheduler for the sum-stationary matmul engine. It accepts one matrix-multiply job: base addresses, row-tile count, column-tile count and inner length. It breaks the job into per-tile instructions for the A-side and B-side `memory_buffer` instances and drives their instruction valid/ready handshakes. It sits between the host/top-level controller and the two buffers, and signals completion only once both buffers have drained.

## Interface
Parameters:
- `N`, 4: tile width (rows per A tile, columns per B tile).
- `MEMORY_ADDRESS_BITS`, 64: address width.
- `MAX_MATRIX_LENGTH`, 4096: maximum inner length K.
- `COUNTER_BITS`, `$clog2(MAX_MATRIX_LENGTH+1)`: width of K.
- `REPEATS_COUNTER_BITS`, `$clog2(MAX_MATRIX_LENGTH/N+1)`: width of tile counts and repeats.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `job_valid` in 1: job request.
- `job_ready` out 1: high in IDLE only.
- `a_base_address` in `MEMORY_ADDRESS_BITS`: A start; row tiles are contiguous, each N*K values.
- `b_base_address` in `MEMORY_ADDRESS_BITS`: B start; column tiles are contiguous, each N*K values.
- `row_tiles` in `REPEATS_COUNTER_BITS`: R, the number of A row tiles.
- `col_tiles` in `REPEATS_COUNTER_BITS`: C, the number of B column tiles.
- `inner_length` in `COUNTER_BITS`: K.
- `a_instruction_valid` out 1, `a_instruction_ready` in 1: A buffer handshake.
- `a_address` out `MEMORY_ADDRESS_BITS`, `a_length` out `COUNTER_BITS`, `a_repeats` out `REPEATS_COUNTER_BITS`: A instruction payload.
- `b_instruction_valid` out 1, `b_instruction_ready` in 1: B buffer handshake.
- `b_address`, `b_length`, `b_repeats` out: B payload, same widths as the A payload.
- `job_done` out 1: one-cycle pulse when the job is complete.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `job_valid && job_ready` latches the job fields and sets `stride_reg = N*K` (truncated to `MEMORY_ADDRESS_BITS`).
  - It clears the counters `a_issued` and `b_row`/`b_col`.
  - Next state is RUN, or DONE_PULSE handling if R, C or K is 0 (see boundaries).
- **A issue:**
  - `a_instruction_valid = (state==RUN) && a_issued < R`.
  - Payload: `a_address = a_base + a_issued*stride` (accumulated register, never a multiplier), `a_length = K`, `a_repeats = C`.
  - On handshake: `a_issued++`, `a_address += stride`.
- **B issue:**
  - `b_instruction_valid = (state==RUN) && b_row < R && b_row < a_issued`. B for row i is never issued before A row i is accepted.
  - Payload: `b_address = b_base + b_col*stride`, `b_length = K`, `b_repeats = 1`.
  - On handshake with `b_col == C-1`: `b_col = 0`, `b_row++`, `b_address = b_base`.
  - On any other handshake: `b_col++`, `b_address += stride`.
- **Simultaneous handshakes:** A and B handshakes in the same cycle are both taken. A B issue gated by `b_row < a_issued` uses the pre-edge `a_issued`.
- **RUN → DRAIN:** when `a_issued == R && b_row == R`, evaluated on registered values.
- **DRAIN:** waits for `a_instruction_ready && b_instruction_ready`. Then `job_done = 1` for one cycle and the state goes to IDLE.
- **Payload stability:** valid and payload are registered and held stable while valid is high and ready is low. Valid never drops without a handshake, except on reset.
- **Boundaries:**
  - R, C or K = 0: no instructions are issued; `job_done` pulses in the cycle after acceptance; back to IDLE.
  - Tile counters wrap only via the explicit `b_col` reset; no counter exceeds R or C.
  - `job_valid` during RUN/DRAIN is ignored, since `job_ready` is 0.
  - Reset mid-job: state goes to IDLE, all valids and `job_done` go to 0, and counters clear. Any downstream buffer state is the buffers' own reset responsibility.
- **Reset values:** `job_ready=1`, `a/b_instruction_valid=0`, `a/b_address=0`, `a/b_length=0`, `a/b_repeats=0`, `job_done=0`.

## Timing
- Job accepted at edge t: `a_instruction_valid` is high in cycle t+1 with the first payload.
- First B valid: one cycle after the first A handshake.
- Back-to-back issue: one instruction per cycle per side when ready is held high.
- DRAIN entry:
  - DRAIN is entered one cycle after the final handshake.
  - Buffers drop `instruction_ready` the cycle after accepting, so a stale ready cannot cause early completion.
  - The DRAIN check is done no earlier than 1 cycle after entry.
- `job_done` lasts exactly 1 cycle; `job_ready` is high in the following cycle.

## Structure
- Shared package `mm_engine_pkg`:
  - State enum `sched_state_t`.
  - Default `N`, `MAX_MATRIX_LENGTH` and the derived width constants, shared with `memory_buffer`.
- Sub-module `tile_issue_channel`:
  - One instance per side.
  - Holds the valid/payload register, the address accumulator and the handshake counter, parameterised by repeats value and wrap count.
  - The top level holds the FSM and the A→B ordering gate.

## Test plan
1. **Basic job:** N=4, K=8, R=2, C=3, a_base=0x1000, b_base=0x2000, readies always 1.
   - A: (0x1000, 8, 3), (0x1020, 8, 3).
   - B: 0x2000, 0x2020, 0x2040, repeated twice, each with length 8 and repeats 1.
   - One `job_done` pulse.
2. **B backpressure:** random B-ready stalls.
   - B payload is stable during stalls.
   - B issue count never exceeds `a_issued*C`.
   - Sequence is identical to scenario 1.
3. **A ready low:** `a_instruction_ready` held low for 20 cycles, then released.
   - No B valid until the first A handshake.
4. **Zero tiles:** C=0, then K=0.
   - No valids asserted.
   - `job_done` pulses the cycle after acceptance.
5. **Drain gating:** hold `b_instruction_ready` low for 10 cycles after the final B handshake.
   - `job_done` is delayed until it is high.
   - `job_ready` stays 0 meanwhile.
6. **Reset mid-job:** reset asserted during RUN after 2 B issues.
   - Next cycle: all valids 0, `job_ready` 1.
   - A new job restarts from the base addresses.
